fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline; sits directly upstream of decode and drives the instruction port of Memory.
- Owns the PC, issues one word fetch per cycle, and buffers fetched words in a small prefetch queue.
- Decode sees a valid/stall handshake instead of a raw memory word.
- Accepts branch/jump redirects from EX, which flush the queue.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS pipeline front end.
// The fetch queue carries each instruction together with its PC+4.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue between the PC/memory port and decode.
// Flush wins over push and pop; push and pop in the same cycle are legal when full.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is reset too, so the head port never shows X to decode.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, fetches one word per cycle into a prefetch
// queue and presents the queue head to decode with a valid/stall handshake.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] instructionAddress,
  input  logic [WORD_W-1:0] instruction,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc_plus4,
  output logic              misalign_err,
  output logic [WORD_W-1:0] fetch_count
);

  logic [WORD_W-1:0]    pc_q, pc_d;
  logic [WORD_W-1:0]    fetch_count_q, fetch_count_d;
  logic                 misalign_q, misalign_d;
  fetch_entry_t         hold_q, hold_d;
  fetch_entry_t         push_data, fifo_head, head_out;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 fifo_empty, fifo_full;
  logic                 enq, deq;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .data  (push_data),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instructionAddress = pc_q;
  assign if_id_valid        = (fifo_count != '0);
  assign deq                = if_id_valid & ~stall;
  assign enq                = ~redirect_valid & (~fifo_full | deq);
  assign push_data          = '{instr: instruction, pc_plus4: pc_q + PC_INC};

  // An empty queue keeps showing the last head so decode never sees X.
  assign head_out       = fifo_empty ? hold_q : fifo_head;
  assign if_id_instr    = head_out.instr;
  assign if_id_pc_plus4 = head_out.pc_plus4;
  assign misalign_err   = misalign_q;
  assign fetch_count    = fetch_count_q;

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q;
    hold_d        = head_out;
    if (redirect_valid) begin
      pc_d       = {redirect_target[WORD_W-1:2], 2'b00};
      misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
    end else if (enq) begin
      pc_d          = pc_q + PC_INC;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
      hold_q        <= '{instr: INSTR_NOP, pc_plus4: '0};
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, directed
// scenarios with literal expectations, then randomized stall/redirect traffic.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .if_id_valid        (if_id_valid),
    .if_id_instr        (if_id_instr),
    .if_id_pc_plus4     (if_id_pc_plus4),
    .misalign_err       (misalign_err),
    .fetch_count        (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  assign instruction = mem_word(instructionAddress);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic        m_mis;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '{instr: 32'h0, pc4: 32'h0};
    m_pc   = 32'h0;
    m_fc   = 32'h0;
    m_mis  = 1'b0;
  endtask

  // One rising edge of the model, applied from the inputs held over that edge.
  task automatic model_update();
    if (redirect_valid) begin
      mq.delete();
      m_pc = {redirect_target[31:2], 2'b00};
      if (redirect_target[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      if (mq.size() > 0 && !stall) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back('{instr: mem_word(m_pc), pc4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        m_fc = m_fc + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    if (mq.size() > 0) m_last = mq[0];
    check("addr",        instructionAddress, m_pc);
    check("valid",       {31'b0, if_id_valid}, {31'b0, mq.size() > 0});
    check("instr",       if_id_instr, m_last.instr);
    check("pc_plus4",    if_id_pc_plus4, m_last.pc4);
    check("misalign",    {31'b0, misalign_err}, {31'b0, m_mis});
    check("fetch_count", fetch_count, m_fc);
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, compare.
  task automatic cycle(input logic s, input logic rv, input logic [31:0] rt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] t;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    #1;
    check("rst_addr",  instructionAddress, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);

    // Streaming from reset
    cycle(1'b0, 1'b0, 32'h0);
    check("s0_instr", if_id_instr, 32'h2000_0000);
    check("s0_pc4",   if_id_pc_plus4, 32'h4);
    check("s0_addr",  instructionAddress, 32'h4);
    cycle(1'b0, 1'b0, 32'h0);
    check("s1_instr", if_id_instr, 32'h2000_0004);
    cycle(1'b0, 1'b0, 32'h0);
    check("s2_instr", if_id_instr, 32'h2000_0008);
    check("s2_pc4",   if_id_pc_plus4, 32'hC);

    // Five stalled cycles with the head at PC 8
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("stall_head", if_id_instr, 32'h2000_0008);
    end
    check("stall_addr", instructionAddress, 32'h10);
    cycle(1'b0, 1'b0, 32'h0);
    check("rel0_instr", if_id_instr, 32'h2000_000C);
    cycle(1'b0, 1'b0, 32'h0);
    check("rel1_instr", if_id_instr, 32'h2000_0010);

    // Redirect to 0x40 with two entries queued
    cycle(1'b0, 1'b1, 32'h40);
    check("rd_valid", {31'b0, if_id_valid}, 32'h0);
    check("rd_addr",  instructionAddress, 32'h40);
    check("rd_fc",    fetch_count, 32'd6);
    cycle(1'b0, 1'b0, 32'h0);
    check("rd_instr", if_id_instr, 32'h2000_0040);
    check("rd_pc4",   if_id_pc_plus4, 32'h44);

    // Misaligned redirect under stall, then an aligned one
    cycle(1'b1, 1'b1, 32'h43);
    check("mis_addr",  instructionAddress, 32'h40);
    check("mis_valid", {31'b0, if_id_valid}, 32'h0);
    check("mis_err",   {31'b0, misalign_err}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h80);
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);

    // PC wrap at 2^32
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_addr0", instructionAddress, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_addr1", instructionAddress, 32'h0);
    check("wrap_instr", if_id_instr, 32'h1FFF_FFFC);
    check("wrap_pc4",   if_id_pc_plus4, 32'h0);

    // Full queue at PC 0x24, then asynchronous reset between edges
    cycle(1'b0, 1'b1, 32'h1C);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("pre_rst_addr", instructionAddress, 32'h24);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr",  instructionAddress, 32'h0);
    check("arst_valid", {31'b0, if_id_valid}, 32'h0);
    check("arst_instr", if_id_instr, 32'h0);
    check("arst_pc4",   if_id_pc_plus4, 32'h0);
    check("arst_mis",   {31'b0, misalign_err}, 32'h0);
    check("arst_fc",    fetch_count, 32'h0);
    model_reset();
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    cycle(1'b0, 1'b0, 32'h0);
    check("restart_instr", if_id_instr, 32'h2000_0000);
    check("restart_addr",  instructionAddress, 32'h4);

    // Randomized stall/redirect traffic
    for (int i = 0; i < 2000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
